// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants, parser states and event type for the PS/2 set-2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes following E1 that belong to the pause sequence
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

    // Keyboard status/ack bytes that never start a scan code
    localparam int NUM_IGNORED = 6;
    localparam logic [8*NUM_IGNORED-1:0] IGNORED_BYTES =
        {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    typedef struct packed {
        logic [3:0] key;
        logic       brk;
    } ps2_event_t;

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORED; i++) begin
            hit = hit | (IGNORED_BYTES[8*i +: 8] == b);
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte input, key bitmap outputs and event-FIFO handshake of the PS/2 key decoder.
interface ps2_key_decoder_if #(parameter int NUM_KEYS = 4);
    logic                rx_done;
    logic [7:0]          rx_data;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                ev_valid;
    logic                ev_ready;
    logic [3:0]          ev_key;
    logic                ev_break;
    logic                overflow;
    logic                clr_ovf;

    modport master (
        output rx_done, rx_data, ev_ready, clr_ovf,
        input  key_held, key_press, key_release, ev_valid, ev_key, ev_break, overflow
    );

    modport slave (
        input  rx_done, rx_data, ev_ready, clr_ovf,
        output key_held, key_press, key_release, ev_valid, ev_key, ev_break, overflow
    );
endinterface

// File: rtl/ps2_key_decoder_sync_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    // A pop frees the slot the same cycle, so a push into a full FIFO still lands
    assign do_push_s = push & (~full | do_pop_s);
    assign head_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix parser, key lookup, held bitmap, press/release pulses, event FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS   = 4,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES  = {9'h05A, 9'h023, 9'h01C, 9'h076},
    parameter int                    FIFO_DEPTH = 8,
    parameter bit                    TYPEMATIC  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);
    ps2_state_e          state_r;
    ps2_state_e          state_nx_s;
    logic [2:0]          skip_cnt_r;
    logic [2:0]          skip_cnt_nx_s;
    logic                act_s;
    logic                act_brk_s;
    logic [8:0]          act_code_s;
    logic                hit_s;
    logic [3:0]          hit_idx_s;
    logic [NUM_KEYS-1:0] hit_oh_s;
    logic [NUM_KEYS-1:0] held_r;
    logic [NUM_KEYS-1:0] press_r;
    logic [NUM_KEYS-1:0] release_r;
    logic                push_r;
    ps2_event_t          push_ev_r;
    ps2_event_t          head_s;
    logic                empty_s;
    logic                full_s;
    logic                overflow_r;

    // Prefix parser: decides next state and whether this byte completes a code
    always_comb begin
        state_nx_s    = state_r;
        skip_cnt_nx_s = skip_cnt_r;
        act_s         = 1'b0;
        act_brk_s     = 1'b0;
        act_code_s    = {1'b0, bus.rx_data};
        if (bus.rx_done) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_data == PS2_EXT) begin
                        state_nx_s = ST_EXT;
                    end else if (bus.rx_data == PS2_BRK) begin
                        state_nx_s = ST_BRK;
                    end else if (bus.rx_data == PS2_PAUSE) begin
                        state_nx_s    = ST_SKIP;
                        skip_cnt_nx_s = PAUSE_SKIP_LEN;
                    end else if (is_ignored(bus.rx_data)) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        act_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == PS2_BRK) begin
                        state_nx_s = ST_EXT_BRK;
                    end else begin
                        act_s      = 1'b1;
                        act_code_s = {1'b1, bus.rx_data};
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    act_s      = 1'b1;
                    act_brk_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    act_s      = 1'b1;
                    act_brk_s  = 1'b1;
                    act_code_s = {1'b1, bus.rx_data};
                    state_nx_s = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_cnt_nx_s = skip_cnt_r - 3'd1;
                    if (skip_cnt_r == 3'd1) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_SKIP;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Key table lookup; the first matching entry claims the code
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 4'd0;
        hit_oh_s  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!hit_s && (act_code_s == KEY_CODES[9*i +: 9])) begin
                hit_s       = 1'b1;
                hit_idx_s   = 4'(i);
                hit_oh_s[i] = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Parser state, held bitmap, one-cycle pulses and the staged FIFO push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= 3'd0;
            held_r     <= '0;
            press_r    <= '0;
            release_r  <= '0;
            push_r     <= 1'b0;
            push_ev_r  <= '0;
        end else begin
            state_r    <= state_nx_s;
            skip_cnt_r <= skip_cnt_nx_s;
            press_r    <= '0;
            release_r  <= '0;
            push_r     <= 1'b0;
            push_ev_r  <= '{key: hit_idx_s, brk: act_brk_s};
            if (act_s && hit_s) begin
                if (act_brk_s) begin
                    held_r    <= held_r & ~hit_oh_s;
                    release_r <= held_r & hit_oh_s;
                    push_r    <= 1'b1;
                end else if ((held_r & hit_oh_s) == '0) begin
                    held_r  <= held_r | hit_oh_s;
                    press_r <= hit_oh_s;
                    push_r  <= 1'b1;
                end else begin
                    held_r <= held_r;
                    push_r <= TYPEMATIC;
                end
            end else begin
                held_r <= held_r;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_r),
        .push_data (push_ev_r),
        .pop       (bus.ev_ready),
        .head_data (head_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Sticky overflow; a push dropped this cycle overrides a clear request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (push_r && full_s && !bus.ev_ready) begin
            overflow_r <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.key_held    = held_r;
    assign bus.key_press   = press_r;
    assign bus.key_release = release_r;
    assign bus.ev_valid    = ~empty_s;
    assign bus.ev_key      = head_s.key;
    assign bus.ev_break    = head_s.brk;
    assign bus.overflow    = overflow_r;
endmodule
